// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order word reads to a variable-latency memory,
// buffered in a prefetch FIFO, flushed and restarted on a control-flow redirect.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req_valid_o,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fetch_pc;
    cnt_t        fifo_count;
    cnt_t        outstanding;
    cnt_t        discard;
    ptr_t        fifo_rd;
    ptr_t        fifo_wr;
    ptr_t        pcq_rd;
    ptr_t        pcq_wr;
    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] pcq       [DEPTH];
    logic [CW:0] in_use;
    logic        issue;
    logic        rsp;
    logic        push;
    logic        pop;
    logic [1:0]  unused_pc_bits;

    assign unused_pc_bits = redirect_pc_i[1:0];

    // Credit check, handshake qualifiers and FIFO head presentation.
    always_comb begin
        in_use          = {1'b0, fifo_count} + {1'b0, outstanding};
        mem_req_valid_o = !reset && !redirect_i && (in_use < DEPTH_C);
        mem_req_addr_o  = fetch_pc;
        issue           = mem_req_valid_o && mem_req_ready_i;
        rsp             = mem_rsp_valid_i && (outstanding != '0);
        push            = rsp && (discard == '0) && !redirect_i;
        inst_valid_o    = (fifo_count != '0);
        pop             = inst_valid_o && inst_ready_i;
        inst_o          = inst_valid_o ? fifo_data[fifo_rd] : '0;
        inst_pc_o       = inst_valid_o ? fifo_pc[fifo_rd] : '0;
    end

    // Fetch address: redirect wins, otherwise advance on an accepted request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // In-flight bookkeeping; outstanding already includes responses owed to
    // earlier redirects, so on a new redirect everything still in flight is stale.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            discard     <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(issue) - cnt_t'(rsp);
            if (issue) begin
                pcq_wr <= pcq_wr + ptr_t'(1);
            end
            if (rsp) begin
                pcq_rd <= pcq_rd + ptr_t'(1);
            end
            if (redirect_i) begin
                discard <= outstanding - cnt_t'(rsp);
            end else if (rsp && (discard != '0)) begin
                discard <= discard - cnt_t'(1);
            end
        end
    end

    // Prefetch FIFO occupancy and pointers; a redirect empties it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_count <= '0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
        end else if (redirect_i) begin
            fifo_count <= '0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
        end else begin
            fifo_count <= fifo_count + cnt_t'(push) - cnt_t'(pop);
            if (push) begin
                fifo_wr <= fifo_wr + ptr_t'(1);
            end
            if (pop) begin
                fifo_rd <= fifo_rd + ptr_t'(1);
            end
        end
    end

    // Storage for request pcs and returned {instruction, pc} pairs.
    always_ff @(posedge clock) begin
        if (issue) begin
            pcq[pcq_wr] <= fetch_pc;
        end
        if (push) begin
            fifo_data[fifo_wr] <= mem_rsp_data_i;
            fifo_pc[fifo_wr]   <= pcq[pcq_rd];
        end
    end

    // The memory may only answer requests it was given.
    a_rsp_owed: assert property (
        @(posedge clock) disable iff (reset)
        mem_rsp_valid_i |-> (outstanding != '0));

    // Credits keep buffered plus in-flight words within the FIFO size.
    a_credit: assert property (
        @(posedge clock) disable iff (reset)
        in_use <= DEPTH_C);

endmodule
